// File: rtl/operand_sweep_pkg.sv
// Shared constants, pin map and state encoding for the operand sweep generator.
// SWEEP_FULL_GRID_EN selects the 64-pair grid sweep instead of the two-pass A/B sweep.
package operand_sweep_pkg;

    localparam int unsigned OPW            = 3;
    localparam int unsigned STEPS_PER_PASS = 8;

    // io_in pin positions
    localparam int unsigned PIN_CLK   = 0;
    localparam int unsigned PIN_RESET = 1;
    localparam int unsigned PIN_START = 2;
    localparam int unsigned PIN_PAUSE = 3;
    localparam int unsigned PIN_LOOP  = 4;

    // io_out field positions
    localparam int unsigned OUT_STROBE = 0;
    localparam int unsigned OUT_A_LSB  = 1;
    localparam int unsigned OUT_B_LSB  = 4;
    localparam int unsigned OUT_DONE   = 7;

    typedef enum logic [2:0] {
        IDLE,
        SWEEP_A,
        SWEEP_B,
        GRID,
        DONE
    } sweep_state_e;

    function automatic logic [7:0] pack_out(input logic           strobe,
                                            input logic [OPW-1:0] a,
                                            input logic [OPW-1:0] b,
                                            input logic           done);
        logic [7:0] o;
        o                   = '0;
        o[OUT_STROBE]       = strobe;
        o[OUT_A_LSB +: OPW] = a;
        o[OUT_B_LSB +: OPW] = b;
        o[OUT_DONE]         = done;
        return o;
    endfunction

endpackage

// File: rtl/sweep_hold_timer.sv
// Per-step hold counter: counts 0..HOLD_CYCLES-1 while enabled and flags the last count.
// Freezes when disabled so a paused step resumes where it stopped.
module sweep_hold_timer
    import operand_sweep_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tc
);

    localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc = en && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/operand_sweep_gen.sv
// Drives the 3-bit A/B operand pair through a fixed sweep with a per-step strobe and done flag.
// Define SWEEP_FULL_GRID_EN to sweep all 64 (A,B) pairs (B outer, A inner) in one GRID pass.
module operand_sweep_gen
    import operand_sweep_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 5
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

`ifdef SWEEP_FULL_GRID_EN
    localparam int unsigned   IDX_W       = 2 * OPW;
    localparam sweep_state_e  FIRST_STATE = GRID;
`else
    localparam int unsigned   IDX_W       = OPW;
    localparam sweep_state_e  FIRST_STATE = SWEEP_A;
`endif
    localparam logic [IDX_W-1:0] IDX_LAST = '1;

    logic clk, rst, start, pause, loop;
    logic unused_pins;

    assign clk         = io_in[PIN_CLK];
    assign rst         = io_in[PIN_RESET];
    assign start       = io_in[PIN_START];
    assign pause       = io_in[PIN_PAUSE];
    assign loop        = io_in[PIN_LOOP];
    assign unused_pins = ^io_in[7:5];

    sweep_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             strobe_d;
    logic [OPW-1:0]   a_d, b_d;
    logic             done_d;
    logic [7:0]       out_q;
    logic             sweeping, hold_tc;

    assign sweeping = (state_q == SWEEP_A) || (state_q == SWEEP_B) || (state_q == GRID);

    sweep_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk (clk),
        .rst (rst),
        .en  (sweeping && !pause),
        .tc  (hold_tc)
    );

    // Strobe is only raised on an edge that enters a new step, so a pause cannot replay it.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        strobe_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = FIRST_STATE;
                    idx_d    = '0;
                    strobe_d = 1'b1;
                end
            end
            SWEEP_A: begin
                if (hold_tc) begin
                    strobe_d = 1'b1;
                    idx_d    = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = SWEEP_B;
                        idx_d   = '0;
                    end
                end
            end
            SWEEP_B: begin
                if (hold_tc) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        strobe_d = 1'b1;
                        idx_d    = idx_q + 1'b1;
                    end
                end
            end
            GRID: begin
`ifdef SWEEP_FULL_GRID_EN
                if (hold_tc) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        strobe_d = 1'b1;
                        idx_d    = idx_q + 1'b1;
                    end
                end
`else
                state_d = IDLE;
                idx_d   = '0;
`endif
            end
            DONE: begin
                if (loop) begin
                    state_d  = FIRST_STATE;
                    idx_d    = '0;
                    strobe_d = 1'b1;
                end else if (!start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Output fields are decoded from the next state so io_out is a pure register.
    always_comb begin
        a_d    = '0;
        b_d    = '0;
        done_d = 1'b0;
        unique case (state_d)
            SWEEP_A: a_d = idx_d[OPW-1:0];
            SWEEP_B: b_d = idx_d[OPW-1:0];
            GRID: begin
`ifdef SWEEP_FULL_GRID_EN
                a_d = idx_d[OPW-1:0];
                b_d = idx_d[IDX_W-1:OPW];
`endif
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            out_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            out_q   <= pack_out(strobe_d, a_d, b_d, done_d);
        end
    end

    assign io_out = out_q;

endmodule

// File: tb/tb_operand_sweep_gen.sv
// Scoreboard bench: stimulus queues hand-computed step events and probes; a monitor checks them.
module tb_operand_sweep_gen;

`ifdef SWEEP_FULL_GRID_EN
    localparam int H0 = 2;
    localparam int N  = 64;
`else
    localparam int H0 = 5;
    localparam int N  = 16;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic loop_en = 1'b0;
    logic sel = 1'b0;
    logic [7:0] io_in;
    logic [7:0] out0, out1, mon;

    // Junk on the unused pins must not matter.
    assign io_in = {3'b101, loop_en, pause, start, rst, clk};
    assign mon   = sel ? out1 : out0;

    operand_sweep_gen #(.HOLD_CYCLES(H0)) dut0 (.io_in(io_in), .io_out(out0));
    operand_sweep_gen #(.HOLD_CYCLES(1))  dut1 (.io_in(io_in), .io_out(out1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] val;
        int         at;
    } ev_t;
    typedef struct {
        string      name;
        logic [7:0] val;
    } probe_t;

    ev_t    q[$];
    probe_t pq[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    logic   end_req = 1'b0;
    logic   end_done = 1'b0;

    // Monitor: one event per strobe cycle or done rising edge, plus queued level probes.
    initial begin
        ev_t    ev;
        probe_t pr;
        logic   done_prev;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (mon[0] || (mon[7] && !done_prev)) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: io_out=%02h at cyc %0d, nothing required",
                             mon, cyc);
                end else begin
                    ev = q.pop_front();
                    if (mon !== ev.val || cyc != ev.at) begin
                        n_bad++;
                        $display("FAIL step_event: got io_out=%02h at cyc %0d, required %02h at cyc %0d",
                                 mon, cyc, ev.val, ev.at);
                    end
                end
            end
            while (pq.size() > 0) begin
                pr = pq.pop_front();
                n_cmp++;
                if (mon !== pr.val) begin
                    n_bad++;
                    $display("FAIL %s: got io_out=%02h, required %02h at cyc %0d",
                             pr.name, mon, pr.val, cyc);
                end
            end
            if (end_req && !end_done) begin
                n_cmp++;
                if (q.size() != 0) begin
                    n_bad++;
                    $display("FAIL pending_events: got %0d unseen, required 0", q.size());
                end
                end_done = 1'b1;
            end
            done_prev = mon[7];
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic probe(input string nm, input logic [7:0] v);
        probe_t p;
        p.name = nm;
        p.val  = v;
        pq.push_back(p);
    endtask

    function automatic logic [7:0] step_val(input int k);
        logic [2:0] a, b;
`ifdef SWEEP_FULL_GRID_EN
        a = 3'(k % 8);
        b = 3'(k / 8);
`else
        a = (k < 8) ? 3'(k) : 3'd0;
        b = (k < 8) ? 3'd0 : 3'(k - 8);
`endif
        return {1'b0, b, a, 1'b1};
    endfunction

    // Queue steps 0..upto-1 starting at cycle 'first'; steps from delay_from on slip by 'delay'.
    task automatic push_sweep(input int first, input int hold, input int upto,
                              input int delay_from, input int delay);
        ev_t e;
        for (int k = 0; k < upto; k++) begin
            e.val = step_val(k);
            e.at  = first + k * hold + ((k >= delay_from) ? delay : 0);
            q.push_back(e);
        end
        if (upto == N) begin
            e.val = 8'h80;
            e.at  = first + N * hold + ((delay_from < N) ? delay : 0);
            q.push_back(e);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        // Reset state and idle without start
        tick(3);
        probe("reset_out", 8'h00);
        rst = 1'b0;
        tick(3);
        probe("idle_no_start", 8'h00);

        // Plain sweep with a one-cycle start pulse
        start = 1'b1;
        s = cyc;
        push_sweep(s + 1, H0, N, N, 0);
        tick();
        start = 1'b0;
        tick(N * H0);
        probe("done_level", 8'h80);
        tick();
        probe("done_one_cycle_idle", 8'h00);
        tick(2);

        // Pause for 7 cycles inside step 3
        start = 1'b1;
        s = cyc;
        push_sweep(s + 1, H0, N, 4, 7);
        tick();
        start = 1'b0;
        tick(3 * H0 + 1);
        pause = 1'b1;
        tick(3);
        probe("paused_hold", 8'h06);
        tick(4);
        pause = 1'b0;
        tick(N * H0 - 3 * H0);
        probe("pause_idle_after", 8'h00);
        tick(2);

        // Reset during step 13 aborts the sweep
        start = 1'b1;
        s = cyc;
        push_sweep(s + 1, H0, 14, N, 0);
        tick();
        start = 1'b0;
        tick(13 * H0 + 1);
        rst = 1'b1;
        tick();
        probe("reset_mid_sweep", 8'h00);
        rst = 1'b0;
        tick(5);
        probe("no_restart_without_start", 8'h00);

        // Loop with start held: two identical sweeps, then hold in DONE
        start   = 1'b1;
        loop_en = 1'b1;
        s = cyc;
        push_sweep(s + 1, H0, N, N, 0);
        push_sweep(s + 2 + N * H0, H0, N, N, 0);
        tick();
        tick(N * H0);
        probe("loop_done_pulse", 8'h80);
        tick();
        probe("loop_restart", 8'h01);
        loop_en = 1'b0;
        tick(N * H0 + 3);
        probe("done_held_by_start", 8'h80);
        start = 1'b0;
        tick();
        probe("done_to_idle", 8'h00);

        // HOLD_CYCLES=1 instance: continuous strobe
        rst = 1'b1;
        tick(2);
        sel = 1'b1;
        tick();
        probe("h1_reset_out", 8'h00);
        rst = 1'b0;
        tick();
        start = 1'b1;
        s = cyc;
        push_sweep(s + 1, 1, N, N, 0);
        tick();
        tick(N);
        tick(3);
        probe("h1_done_held", 8'h80);
        start = 1'b0;
        tick();
        probe("h1_idle", 8'h00);

        end_req = 1'b1;
        tick(3);
        if (!end_done) begin
            $display("FAIL end_check: monitor did not run the final check");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 end_done ? n_bad : n_bad + 1);
        $finish;
    end

endmodule
